// File: rtl/tictactoe_autoplayer.sv
// rtl/tictactoe_autoplayer.sv - automated tic-tac-toe opponent for the game controller
//
// Purpose:
//   Watches the controller's turn flags, board and status. When its own turn
//   is seen it scans the eight treys for a win (and optionally a block) over
//   a fixed number of cycles, picks a square, drives a one-hot sel_pos_o and
//   pulses its side's button for one cycle. An error status marks the square
//   as tried and forces a rescan; a 15-cycle silence rescans without marking.
//
// Ports:
//   clk_i            clock, rising edge
//   reset_i          synchronous active-low reset
//   enable_i         autoplay permitted when high
//   turnX_i/turnO_i  controller turn flags
//   occ_square_i     square occupied mask (bit i = square i)
//   occ_player_i     tile type per square, 1 = X, 0 = O
//   game_st_ascii_i  controller status character, 8'h45 = error
//   sel_pos_o        one-hot selected square, zero when idle
//   buttonX_o        press pulse when PLAYER = 1, else tied 0
//   buttonO_o        press pulse when PLAYER = 0, else tied 0
//   busy_o           high in every state except IDLE
//   stuck_o          sticky: no legal untried square remained at PICK
//   move_cnt_o       accepted moves, saturating at 9
//
// Configuration macro: AUTOPLAY_BLOCK_EN adds the block scan (18-cycle press
// latency); without it the win scan goes straight to PICK (10 cycles).

module tictactoe_autoplayer #(
  parameter int PLAYER = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       turnX_i,
  input  logic       turnO_i,
  input  logic [8:0] occ_square_i,
  input  logic [8:0] occ_player_i,
  input  logic [7:0] game_st_ascii_i,
  output logic [8:0] sel_pos_o,
  output logic       buttonX_o,
  output logic       buttonO_o,
  output logic       busy_o,
  output logic       stuck_o,
  output logic [3:0] move_cnt_o
);

  localparam bit IS_X = (PLAYER != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_WIN,
    S_SCAN_BLOCK,
    S_PICK,
    S_PRESS,
    S_WAIT_ACK,
    S_RETRY
  } state_t;

  state_t     state_q;
  logic [2:0] trey_q;
  logic [3:0] wait_cnt_q;
  logic [8:0] tried_q;
  logic [8:0] win_q;
  logic [8:0] sel_pos_q;
  logic       button_q;
  logic       stuck_q;
  logic [3:0] move_cnt_q;

  logic [8:0] own;
  logic [8:0] free;
  logic       my_turn;
  logic [8:0] win_d;
  logic [8:0] target_d;

  // Squares of trey t, in table order 852, 741, 630, 876, 543, 210, 840, 642.
  function automatic logic [8:0] trey_mask(input logic [2:0] t);
    case (t)
      3'd0:    trey_mask = 9'h124;
      3'd1:    trey_mask = 9'h092;
      3'd2:    trey_mask = 9'h049;
      3'd3:    trey_mask = 9'h1C0;
      3'd4:    trey_mask = 9'h038;
      3'd5:    trey_mask = 9'h007;
      3'd6:    trey_mask = 9'h111;
      default: trey_mask = 9'h054;
    endcase
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    popcount9 = 4'd0;
    for (int i = 0; i < 9; i++) begin
      popcount9 = popcount9 + {3'b000, v[i]};
    end
  endfunction

  // Two of the trey's squares in m and the third free: return that third
  // square one-hot. m is always a subset of the occupied squares, so at most
  // one square of the trey can satisfy the test.
  function automatic logic [8:0] trey_hit(input logic [8:0] m, input logic [8:0] fr,
                                          input logic [2:0] t);
    logic [8:0] tm;
    tm = trey_mask(t);
    if (popcount9(m & tm) == 4'd2) trey_hit = tm & ~m & fr;
    else                           trey_hit = 9'h000;
  endfunction

  // Positional preference: centre, corners, then edges.
  function automatic logic [8:0] fallback(input logic [8:0] fr);
    if      (fr[4]) fallback = 9'h010;
    else if (fr[8]) fallback = 9'h100;
    else if (fr[6]) fallback = 9'h040;
    else if (fr[2]) fallback = 9'h004;
    else if (fr[0]) fallback = 9'h001;
    else if (fr[7]) fallback = 9'h080;
    else if (fr[5]) fallback = 9'h020;
    else if (fr[3]) fallback = 9'h008;
    else if (fr[1]) fallback = 9'h002;
    else            fallback = 9'h000;
  endfunction

  assign own     = occ_square_i & (IS_X ? occ_player_i : ~occ_player_i);
  assign free    = ~occ_square_i & ~tried_q;
  assign my_turn = IS_X ? turnX_i : turnO_i;

  // Candidates including the trey tested this cycle, so the target can be
  // loaded on the same edge that finishes the last scan.
  assign win_d = (state_q == S_SCAN_WIN && win_q == 9'h000) ? trey_hit(own, free, trey_q) : win_q;

`ifdef AUTOPLAY_BLOCK_EN
  logic [8:0] opp;
  logic [8:0] blk_q;
  logic [8:0] blk_d;

  assign opp      = occ_square_i & ~own;
  assign blk_d    = (state_q == S_SCAN_BLOCK && blk_q == 9'h000) ? trey_hit(opp, free, trey_q) : blk_q;
  assign target_d = (win_d != 9'h000) ? win_d :
                    (blk_d != 9'h000) ? blk_d : fallback(free);
`else
  assign target_d = (win_d != 9'h000) ? win_d : fallback(free);
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      trey_q     <= 3'd0;
      wait_cnt_q <= 4'd0;
      tried_q    <= 9'h000;
      win_q      <= 9'h000;
      sel_pos_q  <= 9'h000;
      button_q   <= 1'b0;
      stuck_q    <= 1'b0;
      move_cnt_q <= 4'd0;
`ifdef AUTOPLAY_BLOCK_EN
      blk_q      <= 9'h000;
`endif
    end else begin
      button_q <= 1'b0;
      if (state_q != S_IDLE && !enable_i) begin
        state_q   <= S_IDLE;
        sel_pos_q <= 9'h000;
        tried_q   <= 9'h000;
        trey_q    <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enable_i && my_turn) begin
              state_q <= S_SCAN_WIN;
              trey_q  <= 3'd0;
              win_q   <= 9'h000;
`ifdef AUTOPLAY_BLOCK_EN
              blk_q   <= 9'h000;
`endif
            end
          end
          S_SCAN_WIN: begin
            win_q  <= win_d;
            trey_q <= trey_q + 3'd1;
            if (trey_q == 3'd7) begin
`ifdef AUTOPLAY_BLOCK_EN
              state_q   <= S_SCAN_BLOCK;
`else
              state_q   <= S_PICK;
              sel_pos_q <= target_d;
`endif
            end
          end
`ifdef AUTOPLAY_BLOCK_EN
          S_SCAN_BLOCK: begin
            blk_q  <= blk_d;
            trey_q <= trey_q + 3'd1;
            if (trey_q == 3'd7) begin
              state_q   <= S_PICK;
              sel_pos_q <= target_d;
            end
          end
`endif
          S_PICK: begin
            // A zero target means every square is occupied or tried.
            if (sel_pos_q == 9'h000) begin
              stuck_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              button_q <= 1'b1;
              state_q  <= S_PRESS;
            end
          end
          S_PRESS: begin
            wait_cnt_q <= 4'd0;
            state_q    <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (game_st_ascii_i == 8'h45) begin
              tried_q <= tried_q | sel_pos_q;
              state_q <= S_RETRY;
            end else if (!my_turn) begin
              if (move_cnt_q != 4'd9) move_cnt_q <= move_cnt_q + 4'd1;
              tried_q   <= 9'h000;
              sel_pos_q <= 9'h000;
              state_q   <= S_IDLE;
            end else if (wait_cnt_q == 4'd14) begin
              state_q <= S_RETRY;
            end else begin
              wait_cnt_q <= wait_cnt_q + 4'd1;
            end
          end
          S_RETRY: begin
            sel_pos_q <= 9'h000;
            trey_q    <= 3'd0;
            win_q     <= 9'h000;
`ifdef AUTOPLAY_BLOCK_EN
            blk_q     <= 9'h000;
`endif
            state_q   <= S_SCAN_WIN;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sel_pos_o  = sel_pos_q;
  assign buttonX_o  = IS_X ? button_q : 1'b0;
  assign buttonO_o  = IS_X ? 1'b0 : button_q;
  assign busy_o     = (state_q != S_IDLE);
  assign stuck_o    = stuck_q;
  assign move_cnt_o = move_cnt_q;

endmodule

// File: doc/tictactoe_autoplayer.md
# tictactoe_autoplayer

Automated opponent for the tic-tac-toe game controller. It watches the controller's turn, board and status outputs and plays one side. When its turn comes, it scans the board over a fixed number of cycles, picks a square, drives a one-hot `sel_pos` and pulses that side's button for one cycle. It retries on an error status.

## Interface

Parameters:
- `PLAYER`, default 0: side played. 0 = O (uses `turnO`, drives `buttonO`); 1 = X (uses `turnX`, drives `buttonX`).

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: autoplay permitted when high.
- `turnX` input 1: controller turn flag for X.
- `turnO` input 1: controller turn flag for O.
- `occ_square` input 9: square occupied (bit i = square i).
- `occ_player` input 9: tile type per square (1 = X, 0 = O); valid only where `occ_square` is 1.
- `game_st_ascii` input 8: controller status character; 8'h45 ('E') means error.
- `sel_pos` output 9: one-hot selected square; all-zero when idle.
- `buttonX` output 1: one-cycle press pulse; tied 0 when `PLAYER`=0.
- `buttonO` output 1: one-cycle press pulse; tied 0 when `PLAYER`=1.
- `busy` output 1: high in every state except IDLE.
- `stuck` output 1: sticky flag; set when no legal untried square remains.
- `move_cnt` output 4: count of accepted moves; saturates at 9.

## Operation

- Derived signals:
  - own = `occ_square` & (`PLAYER` ? `occ_player` : ~`occ_player`).
  - opp = `occ_square` & ~own.
  - free = ~`occ_square` & ~tried, where tried is an internal 9-bit mask.
  - my_turn = `PLAYER` ? `turnX` : `turnO`.
- Trey table, index 0..7: 852, 741, 630, 876, 543, 210, 840, 642.
- A trey "hits" for a mask M when two of its squares are in M and its third square is in free. The candidate is that third square. On multiple hits, the lowest trey index wins.
- States and transitions:
  - IDLE: when `enable`=1 and my_turn=1, go to SCAN_WIN, with trey counter t=0.
  - SCAN_WIN: test trey t against own, one trey per cycle. Record the first hit as the win candidate. After t=7, go to SCAN_BLOCK.
  - SCAN_BLOCK: same test against opp, recorded as the block candidate. After t=7, go to PICK.
  - PICK: target = win candidate, else block candidate, else first free square in the order 4, 8, 6, 2, 0, 7, 5, 3, 1. If nothing is free, set `stuck` and go to IDLE with no press. Otherwise drive `sel_pos` = one-hot target and go to PRESS.
  - PRESS: own button = 1 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK:
    - `sel_pos` held stable.
    - If `game_st_ascii`=8'h45: set tried[target] and go to RETRY.
    - Else if my_turn=0: move accepted. Increment `move_cnt`, clear tried, clear `sel_pos`, go to IDLE.
    - Else after 15 cycles with no response: go to RETRY without marking the square.
  - RETRY: clear `sel_pos`, set t=0, go to SCAN_WIN.
- `enable` falling in any non-IDLE state forces IDLE on the next edge: `sel_pos` cleared, no button pulse, tried cleared.
- `stuck` is cleared only by reset.
- A win or cat status character causes no special behaviour; the controller stops asserting turns.

## Timing

- Reset (`reset`=0 at an edge), in any state including mid-scan or mid-press:
  - next cycle state is IDLE;
  - `sel_pos`=0, `buttonX`=`buttonO`=0;
  - `busy`=0, `stuck`=0, `move_cnt`=0;
  - tried=0, trey counter=0.
- Latency is fixed and independent of board contents. If my_turn is first sampled high in IDLE at edge N, the button is high for the cycle after edge N+17. That is 18 cycles with block scan compiled in, 10 without.
- `sel_pos` becomes valid one cycle before the button pulse. It stays stable until the move is accepted, an error is seen, or a timeout occurs.
- The button is never high for two consecutive cycles. At most one press occurs per scan.
- After an accepted move, my_turn must be seen high again in IDLE before a new scan starts. No press occurs during the opponent's turn.
- Board inputs are sampled every scan cycle. A board change mid-scan takes effect only from the next trey tested.

## Configuration

- `AUTOPLAY_BLOCK_EN`
  - Defined: SCAN_BLOCK is present and blocking has priority over positional choice; press latency is 18 cycles.
  - Undefined: SCAN_BLOCK is removed (SCAN_WIN goes straight to PICK) and the block candidate is never used; latency is 10 cycles.

## Test plan

- Empty board, `PLAYER`=0, `turnO` rises -> `buttonO` pulses 18 cycles later, `sel_pos`=9'h010, `busy`=1 throughout; after `turnO` drops, `move_cnt`=1 and `sel_pos`=0.
- Win: `occ_square`=9'h113, `occ_player`=9'h110, `turnO`=1 -> `sel_pos`=9'h004 (trey 210).
- Block: `occ_square`=9'h013, `occ_player`=9'h003, `turnO`=1 -> `sel_pos`=9'h004. With `AUTOPLAY_BLOCK_EN` undefined, the same stimulus -> `sel_pos`=9'h100 after 10 cycles.
- Error retry: empty board; drive `game_st_ascii`=8'h45 two cycles after the press -> RETRY, then a second press 18 cycles later with `sel_pos`=9'h100 (square 4 marked tried).
- `reset`=0 during SCAN_BLOCK -> next cycle all outputs 0 and state IDLE; the next `turnO` starts a full 18-cycle scan.
- Full board (`occ_square`=9'h1FF), `turnO`=1 -> no button pulse, `stuck`=1, returns to IDLE.
